// File: rtl/guess_pkg.sv
// Shared types and constants for the player-side guess-game interface.
package guess_pkg;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      ARMED    = 2'd1,
      PRESSED  = 2'd2,
      RESULT   = 2'd3
   } state_t;

   typedef logic [3:0] btn_t;

   localparam logic [3:0] CNT_MAX = 4'd15;

   function automatic logic is_onehot(input btn_t v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/guess_debounce.sv
// One push-button: 2-FF synchronizer followed by a stable-count debouncer.
module guess_debounce #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic db
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the synced value matches db restarts the stability count.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db = db_q;

endmodule

// File: rtl/guess_player_if.sv
// Player-side end of the guess game: debounced one-hot guess pulses out,
// win/lose result hold and saturating tallies in.
module guess_player_if
   import guess_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = 1_000_000,
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   input  logic       win,
   input  logic       lose,
   output logic [3:0] b,
   output logic       res_win,
   output logic       res_lose,
   output logic [3:0] win_cnt,
   output logic [3:0] lose_cnt,
   output logic       busy
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   btn_t          db;
   state_t        state_q, state_d;
   btn_t          b_q, b_d;
   logic          res_win_q, res_win_d;
   logic          res_lose_q, res_lose_d;
   logic [3:0]    win_cnt_q, win_cnt_d;
   logic [3:0]    lose_cnt_q, lose_cnt_d;
   logic [HW-1:0] hold_q, hold_d;

   for (genvar i = 0; i < 4; i++) begin : g_db
      guess_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(btn_raw[i]),
         .db     (db[i])
      );
   end

   always_comb begin
      state_d    = state_q;
      b_d        = '0;
      res_win_d  = res_win_q;
      res_lose_d = res_lose_q;
      win_cnt_d  = win_cnt_q;
      lose_cnt_d = lose_cnt_q;
      hold_d     = hold_q;

      // A result outranks a simultaneous press; win outranks lose.
      if (state_q != RESULT && (win || lose)) begin
         state_d    = RESULT;
         hold_d     = '0;
         res_win_d  = win;
         res_lose_d = !win;
         if (win) begin
            if (win_cnt_q != CNT_MAX) win_cnt_d = win_cnt_q + 4'd1;
         end else begin
            if (lose_cnt_q != CNT_MAX) lose_cnt_d = lose_cnt_q + 4'd1;
         end
      end else begin
         unique case (state_q)
            WAIT_REL: begin
               if (db == '0) state_d = ARMED;
            end
            ARMED: begin
               if (is_onehot(db)) begin
                  state_d = PRESSED;
                  b_d     = db;
               end else if (db != '0) begin
                  state_d = WAIT_REL;
               end
            end
            PRESSED: begin
               if (db == '0) state_d = ARMED;
            end
            RESULT: begin
               if (hold_q == HOLD_LAST) begin
                  state_d    = WAIT_REL;
                  hold_d     = '0;
                  res_win_d  = 1'b0;
                  res_lose_d = 1'b0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            default: state_d = WAIT_REL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_REL;
         b_q        <= '0;
         res_win_q  <= 1'b0;
         res_lose_q <= 1'b0;
         win_cnt_q  <= '0;
         lose_cnt_q <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         b_q        <= b_d;
         res_win_q  <= res_win_d;
         res_lose_q <= res_lose_d;
         win_cnt_q  <= win_cnt_d;
         lose_cnt_q <= lose_cnt_d;
         hold_q     <= hold_d;
      end
   end

   assign b        = b_q;
   assign res_win  = res_win_q;
   assign res_lose = res_lose_q;
   assign win_cnt  = win_cnt_q;
   assign lose_cnt = lose_cnt_q;
   assign busy     = (state_q != ARMED);

endmodule

// File: tb/tb_guess_player_if.sv
// Directed bench for guess_player_if; b pulses are checked against a scoreboard queue.
module tb_guess_player_if;

   localparam int unsigned DB   = 4;
   localparam int unsigned HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_raw;
   logic       win, lose;
   logic [3:0] b;
   logic       res_win, res_lose;
   logic [3:0] win_cnt, lose_cnt;
   logic       busy;

   int         errors = 0;
   int         checks = 0;
   logic [3:0] exp_q[$];

   guess_player_if #(
      .DB_CYCLES  (DB),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw),
      .win     (win),
      .lose    (lose),
      .b       (b),
      .res_win (res_win),
      .res_lose(res_lose),
      .win_cnt (win_cnt),
      .lose_cnt(lose_cnt),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every nonzero b must match the next expected pulse pushed by the stimulus.
   always @(negedge clk) begin
      if (b !== 4'd0) begin
         if (exp_q.size() == 0) begin
            chk("b_unexpected", 32'(b), 32'd0);
         end else begin
            chk("b_pulse", 32'(b), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic run(input int n, output int pulses, output int first_k);
      pulses  = 0;
      first_k = -1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (b !== 4'd0) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
      end
   endtask

   initial begin
      int pulses, first_k, exp_lose;

      rst = 1'b1; btn_raw = 4'd0; win = 1'b0; lose = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_b", 32'(b), 0);
      chk("rst_res_win", 32'(res_win), 0);
      chk("rst_res_lose", 32'(res_lose), 0);
      chk("rst_win_cnt", 32'(win_cnt), 0);
      chk("rst_lose_cnt", 32'(lose_cnt), 0);
      chk("rst_busy", 32'(busy), 1);
      rst = 1'b0;
      @(negedge clk);
      chk("armed_busy", 32'(busy), 0);

      // 1: single press, pulse exactly at cycle DB+3
      exp_q.push_back(4'b0100);
      btn_raw = 4'b0100;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("t1_b_k%0d", k), 32'(b), (k == 7) ? 32'h4 : 32'h0);
         if (k == 6) chk("t1_busy_before", 32'(busy), 0);
         if (k == 7) chk("t1_busy_after", 32'(busy), 1);
      end
      btn_raw = 4'd0;
      run(10, pulses, first_k);
      chk("t1_release_busy", 32'(busy), 0);

      // 2: bouncing press then stable
      exp_q.push_back(4'b0010);
      btn_raw = 4'b0010; @(negedge clk);
      btn_raw = 4'b0000; @(negedge clk);
      btn_raw = 4'b0010; @(negedge clk);
      btn_raw = 4'b0000; @(negedge clk);
      chk("t2_no_early", 32'(b), 0);
      btn_raw = 4'b0010;
      run(15, pulses, first_k);
      chk("t2_pulses", pulses, 1);
      chk("t2_pulse_cycle", first_k, 7);
      btn_raw = 4'd0;
      run(10, pulses, first_k);

      // 3: multi-hot press is rejected, then a clean press works
      btn_raw = 4'b1001;
      run(12, pulses, first_k);
      chk("t3_multi_pulses", pulses, 0);
      chk("t3_multi_busy", 32'(busy), 1);
      btn_raw = 4'd0;
      run(10, pulses, first_k);
      chk("t3_release_busy", 32'(busy), 0);
      exp_q.push_back(4'b0001);
      btn_raw = 4'b0001;
      run(12, pulses, first_k);
      chk("t3_single_pulses", pulses, 1);
      btn_raw = 4'd0;
      run(10, pulses, first_k);

      // 4: win, hold for HOLD cycles, buttons and extra win ignored meanwhile
      win = 1'b1;
      @(negedge clk);
      win = 1'b0;
      chk("t4_res_win", 32'(res_win), 1);
      chk("t4_res_lose", 32'(res_lose), 0);
      chk("t4_win_cnt", 32'(win_cnt), 1);
      chk("t4_busy", 32'(busy), 1);
      btn_raw = 4'b0100;
      pulses = 0;
      for (int j = 2; j <= 20; j++) begin
         @(negedge clk);
         if (b !== 4'd0) pulses++;
         if (j == 8) chk("t4_hold_last", 32'(res_win), 1);
         if (j == 9) chk("t4_hold_end", 32'(res_win), 0);
         win = (j == 2);
      end
      chk("t4_result_pulses", pulses, 0);
      chk("t4_win_cnt_ignored", 32'(win_cnt), 1);
      chk("t4_held_busy", 32'(busy), 1);
      btn_raw = 4'd0;
      run(10, pulses, first_k);

      // 5: win beats lose; lose tally saturates
      win = 1'b1; lose = 1'b1;
      @(negedge clk);
      win = 1'b0; lose = 1'b0;
      chk("t5_res_win", 32'(res_win), 1);
      chk("t5_res_lose", 32'(res_lose), 0);
      chk("t5_win_cnt", 32'(win_cnt), 2);
      chk("t5_lose_cnt", 32'(lose_cnt), 0);
      run(10, pulses, first_k);
      for (int i = 0; i < 16; i++) begin
         lose = 1'b1;
         @(negedge clk);
         lose = 1'b0;
         exp_lose = (i + 1 > 15) ? 15 : i + 1;
         chk($sformatf("t5_res_lose_%0d", i), 32'(res_lose), 1);
         chk($sformatf("t5_lose_cnt_%0d", i), 32'(lose_cnt), exp_lose);
         run(9, pulses, first_k);
      end
      chk("t5_win_cnt_final", 32'(win_cnt), 2);

      // 6: async reset mid-RESULT and mid-pulse
      win = 1'b1;
      @(negedge clk);
      win = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_in_result", 32'(res_win), 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_res_win", 32'(res_win), 0);
      chk("t6_rst_win_cnt", 32'(win_cnt), 0);
      chk("t6_rst_lose_cnt", 32'(lose_cnt), 0);
      chk("t6_rst_busy", 32'(busy), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(4'b0100);
      btn_raw = 4'b0100;
      repeat (7) @(negedge clk);
      chk("t6_mid_pulse", 32'(b), 32'h4);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_b", 32'(b), 0);
      chk("t6_rst_busy2", 32'(busy), 1);
      @(negedge clk);
      rst = 1'b0;
      // Button still held: re-debounced once, then must be released to fire again.
      exp_q.push_back(4'b0100);
      run(20, pulses, first_k);
      chk("t6_held_pulses", pulses, 1);
      chk("t6_held_cycle", first_k, 7);
      run(10, pulses, first_k);
      chk("t6_still_held", pulses, 0);
      btn_raw = 4'd0;
      run(10, pulses, first_k);
      exp_q.push_back(4'b1000);
      btn_raw = 4'b1000;
      run(12, pulses, first_k);
      chk("t6_repress", pulses, 1);
      btn_raw = 4'd0;
      run(10, pulses, first_k);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
